// File: rtl/sc_speedcounter_pkg.sv
// Shared definitions for the speed counter slice.
//   scState_t        : controller states (IDLE, RUN, HOLD)
//   THRESHOLD_LEVELx : comparator thresholds for each level, 23-bit count
//   periodCycles()   : cycles per tick period for a given threshold
//                      (count runs 0..threshold, then clears)
package sc_speedcounter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } scState_t;

  // Level 00 terminates exactly at the all-ones count, so it never wraps.
  localparam int unsigned THRESHOLD_LEVEL0 = 32'd8388607;
  localparam int unsigned THRESHOLD_LEVEL1 = 32'd4194304;
  localparam int unsigned THRESHOLD_LEVEL2 = 32'd4063232;
  localparam int unsigned THRESHOLD_LEVEL3 = 32'd2097152;

  // Period is threshold+1 because the threshold count itself is a cycle.
  function automatic int unsigned periodCycles(input int unsigned threshold);
    return threshold + 32'd1;
  endfunction

endpackage

// File: rtl/sc_speedcounter_levelreg.sv
// Applied-level register for the speed counter.
// The requested level is treated as pending: it is only copied into the
// applied level while the controller is idle (or being disabled), or on a
// terminal-flag clear. Mid-period requests therefore cannot lower the
// comparator threshold below the running count.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset (level -> 0)
//   loadIdle  : load request every cycle while idle / disabled
//   loadClear : load request on a terminal-flag clear
//   levelReq  : requested level from the game controller
//   level     : applied level driven to the comparator
module sc_speedcounter_levelreg #(
  parameter int NIVELWIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  loadIdle,
  input  logic                  loadClear,
  input  logic [NIVELWIDTH-1:0] levelReq,
  output logic [NIVELWIDTH-1:0] level
);

  // Frozen whenever neither load condition holds (RUN mid-period, HOLD).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else if (loadIdle || loadClear) begin
      level <= levelReq;
    end
  end

endmodule

// File: rtl/sc_speedcounter.sv
// Free-running speed counter feeding the speed comparator.
// The count and applied level go to the comparator; its active-low
// terminal flag comes back on T0 and clears the count, pulses TICK and
// applies any pending level request.
// Optional feature macro: SC_SPEEDCOUNTER_TICKCOUNT_EN adds an 8-bit
// wrapping tick counter output, cleared when the controller drops to IDLE.
// Ports:
//   SC_SPEEDCOUNTER_CLOCK_50         : system clock, rising edge
//   SC_SPEEDCOUNTER_RESET_InLow      : asynchronous active-low reset
//   SC_SPEEDCOUNTER_ENABLE_InHigh    : run request, low forces IDLE
//   SC_SPEEDCOUNTER_PAUSE_InHigh     : freeze request while running
//   SC_SPEEDCOUNTER_NIVELREQ_InBus   : requested level
//   SC_SPEEDCOUNTER_T0_InLow         : comparator terminal flag
//   SC_SPEEDCOUNTER_data_OutBUS      : current count
//   SC_SPEEDCOUNTER_NIVEL_OutBus     : applied level
//   SC_SPEEDCOUNTER_TICK_OutHigh     : one-cycle pulse per completed period
//   SC_SPEEDCOUNTER_TICKCOUNT_OutBus : tick counter (feature macro only)
//   SC_SPEEDCOUNTER_OVERFLOW_OutHigh : sticky count-wrap flag
module sc_speedcounter
  import sc_speedcounter_pkg::*;
#(
  parameter int SPEEDCOUNTER_DATAWIDTH  = 23,
  parameter int SPEEDCOUNTER_NIVELWIDTH = 2
) (
  input  logic                               SC_SPEEDCOUNTER_CLOCK_50,
  input  logic                               SC_SPEEDCOUNTER_RESET_InLow,
  input  logic                               SC_SPEEDCOUNTER_ENABLE_InHigh,
  input  logic                               SC_SPEEDCOUNTER_PAUSE_InHigh,
  input  logic [SPEEDCOUNTER_NIVELWIDTH-1:0] SC_SPEEDCOUNTER_NIVELREQ_InBus,
  input  logic                               SC_SPEEDCOUNTER_T0_InLow,
  output logic [SPEEDCOUNTER_DATAWIDTH-1:0]  SC_SPEEDCOUNTER_data_OutBUS,
  output logic [SPEEDCOUNTER_NIVELWIDTH-1:0] SC_SPEEDCOUNTER_NIVEL_OutBus,
  output logic                               SC_SPEEDCOUNTER_TICK_OutHigh,
`ifdef SC_SPEEDCOUNTER_TICKCOUNT_EN
  output logic [7:0]                         SC_SPEEDCOUNTER_TICKCOUNT_OutBus,
`endif
  output logic                               SC_SPEEDCOUNTER_OVERFLOW_OutHigh
);

  localparam logic [SPEEDCOUNTER_DATAWIDTH-1:0] COUNT_MAX = {SPEEDCOUNTER_DATAWIDTH{1'b1}};
  localparam logic [SPEEDCOUNTER_DATAWIDTH-1:0] COUNT_ONE = {{(SPEEDCOUNTER_DATAWIDTH-1){1'b0}}, 1'b1};

  logic                              clk;
  logic                              rst_n;
  logic                              enable;
  logic                              pause;
  logic                              t0Low;
  scState_t                          state;
  scState_t                          stateNext;
  logic [SPEEDCOUNTER_DATAWIDTH-1:0] count;
  logic                              counting;
  logic                              clearEvent;
  logic                              wrapEvent;
  logic                              idleLoad;

  assign clk    = SC_SPEEDCOUNTER_CLOCK_50;
  assign rst_n  = SC_SPEEDCOUNTER_RESET_InLow;
  assign enable = SC_SPEEDCOUNTER_ENABLE_InHigh;
  assign pause  = SC_SPEEDCOUNTER_PAUSE_InHigh;
  assign t0Low  = SC_SPEEDCOUNTER_T0_InLow;

  // A HOLD edge with PAUSE released counts exactly like a RUN edge, so a
  // pause of N cycles shifts the tick schedule by exactly N cycles and a
  // count frozen at the threshold ticks on the resume edge.
  assign counting   = enable && !pause && (state == RUN || state == HOLD);
  assign clearEvent = counting && !t0Low;
  assign wrapEvent  = counting && t0Low && (count == COUNT_MAX);
  assign idleLoad   = !enable || (state == IDLE);

  // Next state; ENABLE outranks PAUSE, which outranks the terminal flag.
  always_comb begin
    stateNext = state;
    if (!enable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    stateNext = RUN;
        RUN:     if (pause) stateNext = HOLD;
        HOLD:    if (!pause) stateNext = RUN;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Count, tick and overflow. The entry edge from IDLE leaves the count at
  // 0, so a period spans counts 0..threshold = periodCycles(threshold).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                            <= IDLE;
      count                            <= '0;
      SC_SPEEDCOUNTER_TICK_OutHigh     <= 1'b0;
      SC_SPEEDCOUNTER_OVERFLOW_OutHigh <= 1'b0;
    end else begin
      state                        <= stateNext;
      SC_SPEEDCOUNTER_TICK_OutHigh <= clearEvent;
      if (idleLoad || clearEvent) begin
        count <= '0;
      end else if (counting) begin
        count <= count + COUNT_ONE;
      end
      if (wrapEvent) begin
        SC_SPEEDCOUNTER_OVERFLOW_OutHigh <= 1'b1;
      end
    end
  end

  assign SC_SPEEDCOUNTER_data_OutBUS = count;

  sc_speedcounter_levelreg #(
    .NIVELWIDTH(SPEEDCOUNTER_NIVELWIDTH)
  ) levelReg (
    .clk      (clk),
    .rst_n    (rst_n),
    .loadIdle (idleLoad),
    .loadClear(clearEvent),
    .levelReq (SC_SPEEDCOUNTER_NIVELREQ_InBus),
    .level    (SC_SPEEDCOUNTER_NIVEL_OutBus)
  );

`ifdef SC_SPEEDCOUNTER_TICKCOUNT_EN
  logic [7:0] tickCount;

  // Counts terminal clears (the edges that raise TICK); wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCount <= 8'd0;
    end else if (!enable) begin
      tickCount <= 8'd0;
    end else if (clearEvent) begin
      tickCount <= tickCount + 8'd1;
    end
  end

  assign SC_SPEEDCOUNTER_TICKCOUNT_OutBus = tickCount;
`endif

endmodule
